// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing generator.
// Counts pixel ticks, derived from the rising edges of vga_clk_i, into an
// h/v raster position and decodes the syncs, the visible-region flag and a
// start-of-frame pulse. All outputs are registered and update on the same
// clk_i edge as the counters.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to add the 8-bit
// frame_cnt_o output.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vga_clk_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       frame_start_o
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       vga_clk_q;
  logic       pix_tick;
  logic [9:0] h_q;
  logic [9:0] h_d;
  logic [9:0] v_q;
  logic [9:0] v_d;
  logic       hsync_q;
  logic       hsync_d;
  logic       vsync_q;
  logic       vsync_d;
  logic       active_q;
  logic       active_d;
  logic       frame_start_q;
  logic       frame_start_d;

  // Pixel tick on each vga_clk_i rising edge. vga_clk_q resets to 1 so a
  // level already high at reset release is not mistaken for an edge.
  assign pix_tick = vga_clk_i & ~vga_clk_q;

  // Next raster position: advance on a tick, wrap at end of line and frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Decode outputs from the next position so they line up with the counters.
  always_comb begin
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    active_d      = 1'b0;
    frame_start_d = 1'b0;
    if ((h_d >= HS_BEG) && (h_d < HS_END)) begin
      hsync_d = 1'b0;
    end else begin
      hsync_d = 1'b1;
    end
    if ((v_d >= VS_BEG) && (v_d < VS_END)) begin
      vsync_d = 1'b0;
    end else begin
      vsync_d = 1'b1;
    end
    if ((h_d < H_ACT) && (v_d < V_ACT)) begin
      active_d = 1'b1;
    end else begin
      active_d = 1'b0;
    end
    if (pix_tick && (h_d == 10'd0) && (v_d == 10'd0)) begin
      frame_start_d = 1'b1;
    end else begin
      frame_start_d = 1'b0;
    end
  end

  // Counter and output registers; reset parks the raster on the last pixel
  // of the frame so the first tick lands on (0,0) and starts a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vga_clk_q     <= 1'b1;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vga_clk_q     <= vga_clk_i;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x_o           = h_q;
  assign y_o           = v_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign active_o      = active_q;
  assign frame_start_o = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Frame counter steps together with the frame_start_o pulse, wrapping at 255.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen.
// d0 uses the default 640x480 timing; d1 uses a tiny raster (8x7) so that
// whole frames, frame periods and the frame counter fit in a short run.
module tb_vga_sync_gen;

  localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 3, SVF = 1, SVS = 2, SVB = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       vclk = 1'b0;
  logic       hs0, vs0, act0, fs0, hs1, vs1, act1, fs1;
  logic [9:0] x0, y0, x1, y1;
  logic [7:0] fc0, fc1;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[9];

  int   cnt_chk  = 0;
  int   cnt_fail = 0;
  int   n        = 0;
  int   cyc      = 0;
  bit   prev_v   = 1'b1;
  bit   tick     = 1'b0;
  int   last_fs  = -1;
  bit   meas     = 1'b0;
  int   x0_first = -1;
  int   x0_second = -1;
  int   hs_cnt   = 0;
  int   act_cnt  = 0;
  logic [9:0] px = 10'd0;

  always #5 clk = ~clk;

  vga_sync_gen d0 (
    .clk_i(clk), .rst_i(rst), .vga_clk_i(vclk),
    .hsync_o(hs0), .vsync_o(vs0), .active_o(act0),
    .x_o(x0), .y_o(y0), .frame_start_o(fs0)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt_o(fc0)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) d1 (
    .clk_i(clk), .rst_i(rst), .vga_clk_i(vclk),
    .hsync_o(hs1), .vsync_o(vs1), .active_o(act1),
    .x_o(x1), .y_o(y1), .frame_start_o(fs1)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt_o(fc1)
`endif
  );

`ifndef VGA_SYNC_FRAME_CNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif

  // Reference: position is simply (ticks since reset - 1) folded into the raster.
  function automatic exp_t model(int nn, bit tk, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, p, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (nn == 0) begin
      e = '{x: 10'(ht - 1), y: 10'(vt - 1), hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, fc: 8'd0};
    end else begin
      p = (nn - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.hs  = !((x >= ha + hf) && (x < ha + hf + hsw));
      e.vs  = !((y >= va + vf) && (y < va + vf + vsw));
      e.act = (x < ha) && (y < va);
      e.fs  = tk && (p == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
      e.fc  = 8'((((nn - 1) / (ht * vt)) + 1) % 256);
`else
      e.fc  = 8'd0;
`endif
    end
    return e;
  endfunction

  task automatic chk(string nm, exp_t a, exp_t e);
    cnt_chk++;
    if (a !== e) begin
      cnt_fail++;
      $display("FAIL %s @cyc %0d: got x=%0d y=%0d hs=%0b vs=%0b act=%0b fs=%0b fc=%0d, expected x=%0d y=%0d hs=%0b vs=%0b act=%0b fs=%0b fc=%0d",
               nm, cyc, a.x, a.y, a.hs, a.vs, a.act, a.fs, a.fc,
               e.x, e.y, e.hs, e.vs, e.act, e.fs, e.fc);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    cnt_chk++;
    if (a !== e) begin
      cnt_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, a, e);
    end
  endtask

  // One clk_i cycle: drive vga_clk on the falling edge, push expectations,
  // then sample just after the rising edge and score both instances.
  task automatic step(input logic v);
    exp_t e;
    @(negedge clk);
    vclk = v;
    if (rst) begin
      n = 0; prev_v = 1'b1; tick = 1'b0; last_fs = -1;
    end else begin
      tick = v & ~prev_v;
      prev_v = v;
      if (tick) n++;
    end
    q0.push_back(model(n, tick, 640, 16, 96, 48, 480, 10, 2, 33));
    q1.push_back(model(n, tick, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
    @(posedge clk);
    #1;
    cyc++;
    e = q0.pop_front();
    chk("d0_scoreboard", {x0, y0, hs0, vs0, act0, fs0, fc0}, e);
    e = q1.pop_front();
    chk("d1_scoreboard", {x1, y1, hs1, vs1, act1, fs1, fc1}, e);
    if (!rst && fs1) begin
      if (last_fs >= 0) chk_int("d1_frame_period", cyc - last_fs, 112);
      last_fs = cyc;
    end
    if (meas) begin
      if (x0 == 10'd0 && px != 10'd0) begin
        if (x0_first < 0) x0_first = cyc;
        else begin x0_second = cyc; meas = 1'b0; end
      end
      if (meas) begin
        if (!hs0) hs_cnt++;
        if (act0) act_cnt++;
      end
    end
    px = x0;
  endtask

  task automatic run_to(int target);
    int g;
    g = 0;
    while (n < target && g < 100000) begin
      step(~vclk);
      g++;
    end
    chk_int("run_to_tick_count", n, target);
  endtask

  initial begin
    tbl[0] = '{n:   1, x: 10'd0,   y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b1, fs: 1'b1};
    tbl[1] = '{n: 640, x: 10'd639, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b1, fs: 1'b0};
    tbl[2] = '{n: 641, x: 10'd640, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[3] = '{n: 656, x: 10'd655, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[4] = '{n: 657, x: 10'd656, y: 10'd0, hs: 1'b0, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[5] = '{n: 752, x: 10'd751, y: 10'd0, hs: 1'b0, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[6] = '{n: 753, x: 10'd752, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[7] = '{n: 800, x: 10'd799, y: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};
    tbl[8] = '{n: 801, x: 10'd0,   y: 10'd1, hs: 1'b1, vs: 1'b1, act: 1'b1, fs: 1'b0};

    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    rst  = 1'b0;
    meas = 1'b1;

    // First line of the default raster, checked at its timing boundaries.
    for (int k = 0; k < 9; k++) begin
      run_to(tbl[k].n);
      cnt_chk++;
      if ({x0, y0, hs0, vs0, act0, fs0} !== {tbl[k].x, tbl[k].y, tbl[k].hs, tbl[k].vs, tbl[k].act, tbl[k].fs}) begin
        cnt_fail++;
        $display("FAIL line_vec[%0d] n=%0d: got x=%0d y=%0d hs=%0b vs=%0b act=%0b fs=%0b, expected x=%0d y=%0d hs=%0b vs=%0b act=%0b fs=%0b",
                 k, tbl[k].n, x0, y0, hs0, vs0, act0, fs0,
                 tbl[k].x, tbl[k].y, tbl[k].hs, tbl[k].vs, tbl[k].act, tbl[k].fs);
      end
    end
    chk_int("line_period_cycles", x0_second - x0_first, 1600);
    chk_int("hsync_low_cycles", hs_cnt, 192);
    chk_int("active_cycles", act_cnt, 1280);

    // vga_clk held high for 100 cycles: everything frozen, then resumes.
    for (int i = 0; i < 100; i++) step(1'b1);
    step(1'b0);
    step(1'b1);
    chk_int("resume_x", int'(x0), 1);
    chk_int("resume_y", int'(y0), 1);
    last_fs = -1;

    // 257 frames of the small raster (frame counter wraps through 255).
    run_to(256 * 56 + 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk_int("frame_cnt_after_257", int'(fc1), 1);
`endif

    // Reset mid-frame while both syncs of the small raster are low.
    run_to(256 * 56 + 1 + 45);
    chk_int("pre_rst_hsync_low", int'(hs1), 0);
    chk_int("pre_rst_vsync_low", int'(vs1), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_d0", {x0, y0, hs0, vs0, act0, fs0, fc0},
        '{x: 10'd799, y: 10'd524, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, fc: 8'd0});
    chk("async_rst_d1", {x1, y1, hs1, vs1, act1, fs1, fc1},
        '{x: 10'd7, y: 10'd6, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, fc: 8'd0});
    step(1'b1);
    step(1'b0);
    rst = 1'b0;
    run_to(1);
    chk_int("restart_fs_d0", int'(fs0), 1);
    chk_int("restart_fs_d1", int'(fs1), 1);
    chk_int("restart_xy_d1", int'({x1, y1}), 0);
    run_to(130);

    $display("End of test - %0d assertions evaluated, %0d failures", cnt_chk, cnt_fail);
    $finish;
  end

endmodule
